// File: rtl/bus_rx8_pkg.sv
// bus_rx8 shared constants and helpers.
// Default sizes, pointer/count widths, even-parity helper.
package bus_rx8_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 4;
  localparam int PW_DEF    = $clog2(DEPTH_DEF);
  localparam int CW_DEF    = PW_DEF + 1;

  // Widest word the parity helper accepts;
  // callers zero-extend, which leaves parity intact.
  localparam int PAR_MAXW  = 64;

  // 1 when the word has an odd number of ones.
  function automatic logic even_par(
    input logic [PAR_MAXW-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: EW x DEPTH register array, one write port,
// one asynchronous read port; storage is never reset.
//   c          clock (rising edge)
//   we/wa/wd   write enable, address, data
//   ra/rd      read address, combinational read data
module fifo_ram #(
  parameter int EW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          c,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [EW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [EW-1:0] rd
);

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge c) begin
    if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd = mem_q[ra];

endmodule

// File: rtl/bus_rx8.sv
// bus_rx8: tri-state bus receiver with FWFT FIFO, valid/ready
// output and sticky overflow. Optional parity: BUS_RX8_PARITY_EN.
//   c, r           clock (rising), async active-low reset
//   a, stb         bus word, strobe (a sampled only when stb=1)
//   y, vld, rdy    head word, head valid, consumer accept
//   full           FIFO holds DEPTH words
//   ovf, clr       sticky drop flag, synchronous clear
//   ap, ype, perr  (parity build) parity in, head error, sticky error
module bus_rx8
  import bus_rx8_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         c,
  input  logic         r,
  input  logic [W-1:0] a,
  input  logic         stb,
  output logic [W-1:0] y,
  output logic         vld,
  input  logic         rdy,
  output logic         full,
  output logic         ovf,
  input  logic         clr
`ifdef BUS_RX8_PARITY_EN
  ,
  input  logic         ap,
  output logic         ype,
  output logic         perr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef BUS_RX8_PARITY_EN
  localparam int EW = W + 1;
`else
  localparam int EW = W;
`endif

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  yh_q, yh_d;

  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] wd;
  logic [EW-1:0] rd;

  assign vld  = (cnt_q != '0);
  assign full = (cnt_q == CW'(DEPTH));

  // A pop frees the slot the push lands in,
  // so a full FIFO still accepts a word when popped.
  assign pop  = vld & rdy;
  assign push = stb & (~full | pop);
  assign drop = stb & ~push;

`ifdef BUS_RX8_PARITY_EN
  logic pe_in;
  logic perr_q, perr_d;

  assign pe_in = even_par(PAR_MAXW'({ap, a}));
  assign wd    = {pe_in, a};
  assign ype   = vld & rd[W];
  assign perr  = perr_q;

  always_comb begin
    perr_d = perr_q & ~clr;
    if (push & pe_in) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
`else
  assign wd = a;
`endif

  fifo_ram #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .c  (c),
    .we (push),
    .wa (wp_q),
    .wd (wd),
    .ra (rp_q),
    .rd (rd)
  );

  // Head comes straight from storage; once empty,
  // y replays the last word handed out.
  assign y   = vld ? rd[W-1:0] : yh_q;
  assign ovf = ovf_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    yh_d  = yh_q;
    if (push) begin
      wp_d = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
      yh_d = rd[W-1:0];
    end
    unique case (1'b1)
      push & ~pop: cnt_d = cnt_q + 1'b1;
      pop & ~push: cnt_d = cnt_q - 1'b1;
      default:     ;
    endcase
  end

  // Set beats clear when a drop meets clr.
  always_comb begin
    ovf_d = ovf_q & ~clr;
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      yh_q  <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      yh_q  <= yh_d;
    end
  end

endmodule

// File: tb/tb_bus_rx8.sv
// tb_bus_rx8: directed stimulus, queue-based reference model,
// per-cycle compare plus literal checks.
module tb_bus_rx8;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         c   = 1'b0;
  logic         r   = 1'b0;
  logic [W-1:0] a   = '0;
  logic         stb = 1'b0;
  logic         rdy = 1'b0;
  logic         clr = 1'b0;
  logic         ap  = 1'b0;
  logic [W-1:0] y;
  logic         vld;
  logic         full;
  logic         ovf;
`ifdef BUS_RX8_PARITY_EN
  logic         ype;
  logic         perr;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  bus_rx8 #(.W(W), .DEPTH(DEPTH)) dut (
    .c    (c),
    .r    (r),
    .a    (a),
    .stb  (stb),
    .y    (y),
    .vld  (vld),
    .rdy  (rdy),
    .full (full),
    .ovf  (ovf),
    .clr  (clr)
`ifdef BUS_RX8_PARITY_EN
    ,
    .ap   (ap),
    .ype  (ype),
    .perr (perr)
`endif
  );

  always #5 c = ~c;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {parity_err, word}.
  logic [W:0]   mq[$];
  logic [W-1:0] m_last = '0;
  logic         m_ovf  = 1'b0;
  logic         m_perr = 1'b0;
  logic [W:0]   m_tmp;
  bit           m_pop, m_push, m_drop;

  always @(posedge c or negedge r) begin
    if (!r) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && rdy;
      m_push = stb && ((mq.size() < DEPTH) || m_pop);
      m_drop = stb && !m_push;
      if (m_pop) begin
        m_tmp  = mq.pop_front();
        m_last = m_tmp[W-1:0];
      end
      if (m_push) mq.push_back({^{ap, a}, a});
      if (clr) m_ovf = 1'b0;
      if (m_drop) m_ovf = 1'b1;
      if (clr) m_perr = 1'b0;
      if (m_push && (^{ap, a})) m_perr = 1'b1;
    end
  end

  always @(negedge c) begin
    chk("m_vld", 32'(vld), 32'(mq.size() != 0));
    chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
    chk("m_y", 32'(y),
        (mq.size() != 0) ? 32'(mq[0][W-1:0]) : 32'(m_last));
`ifdef BUS_RX8_PARITY_EN
    chk("m_ype", 32'(ype),
        (mq.size() != 0) ? 32'(mq[0][W]) : 32'd0);
    chk("m_perr", 32'(perr), 32'(m_perr));
`endif
  end

  // Apply inputs for one rising edge, return at the
  // following falling edge with inputs idle again.
  task automatic cyc(input logic s, input logic [W-1:0] d,
                     input logic rd_, input logic cl);
    stb = s;
    a   = d;
    rdy = rd_;
    clr = cl;
    @(negedge c);
    stb = 1'b0;
    a   = '0;
    rdy = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    // Reset then single word
    r = 1'b0;
    @(negedge c);
    @(negedge c);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    r = 1'b1;
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("one_vld", 32'(vld), 32'd1);
    chk("one_y", 32'(y), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("one_pop_vld", 32'(vld), 32'd0);
    chk("one_hold_y", 32'(y), 32'hA5);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, W'(i), 1'b0, 1'b0);
      chk("fill_full", 32'(full), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("fill_ovf0", 32'(ovf), 32'd0);
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_y", 32'(y), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_vld", 32'(vld), 32'd0);

    // Clear without drop
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    chk("pp_full0", 32'(full), 32'd1);
    cyc(1'b1, 8'h14, 1'b1, 1'b0);
    chk("pp_ovf", 32'(ovf), 32'd0);
    chk("pp_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("pp_y", 32'(y), 32'(8'h11 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pp_vld", 32'(vld), 32'd0);

    // Clear vs simultaneous drop
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h24, 1'b0, 1'b0);
    chk("cd_ovf1", 32'(ovf), 32'd1);
    cyc(1'b1, 8'h25, 1'b0, 1'b1);
    chk("cd_ovf_set_wins", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("cd_y", 32'(y), 32'(8'h20 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Streaming through pointer wrap
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      chk("st_y", 32'(y), 32'(i - 1));
      cyc(1'b1, W'(i), 1'b1, 1'b0);
      chk("st_vld", 32'(vld), 32'd1);
      chk("st_full", 32'(full), 32'd0);
    end
    chk("st_last", 32'(y), 32'd19);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("st_end_vld", 32'(vld), 32'd0);

    // Async reset mid-stream
    cyc(1'b1, 8'h30, 1'b0, 1'b0);
    cyc(1'b1, 8'h31, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 1'b0, 1'b0);
    chk("ar_pre_ovf", 32'(ovf), 32'd1);
    #7;
    r = 1'b0;
    #1;
    chk("ar_vld", 32'(vld), 32'd0);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_ovf", 32'(ovf), 32'd0);
    chk("ar_y", 32'(y), 32'd0);
    @(negedge c);
    r = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("ar_3c_y", 32'(y), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ar_3c_alone", 32'(vld), 32'd0);

`ifdef BUS_RX8_PARITY_EN
    ap = 1'b0;
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    chk("par_ype0", 32'(ype), 32'd0);
    chk("par_perr0", 32'(perr), 32'd0);
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    chk("par_perr1", 32'(perr), 32'd1);
    chk("par_head_ok", 32'(ype), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("par_ype1", 32'(ype), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("par_empty_ype", 32'(ype), 32'd0);
`endif

    repeat (2) @(negedge c);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bus_rx8.md
Name: bus_rx8

Overview:
- Receiving end of the shared 8-bit tri-state data bus whose drivers release to high-impedance when disabled.
- Samples the bus on a driver strobe and buffers the words in a small first-word-fall-through (FWFT) FIFO.
- Presents the words to the local consumer with a valid/ready handshake.
- Flags words lost to overflow with a sticky status bit.

Parameters:
- W, 8, bus/data width in bits.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- c  input  1  clock, rising-edge active.
- r  input  1  reset, asynchronous, active-low.
- a  input  W  bus data, sampled only when stb=1.
- stb  input  1  driver strobe: bus holds a valid word this cycle.
- y  output  W  head-of-FIFO word (FWFT).
- vld  output  1  y is valid (FIFO not empty).
- rdy  input  1  consumer accepts y this cycle.
- full  output  1  FIFO holds DEPTH words.
- ovf  output  1  sticky overflow: at least one strobed word was dropped.
- clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (r=0, asynchronous): read/write pointers=0, count=0, vld=0, full=0, ovf=0, y=0. FIFO storage is not reset.
- Reset mid-operation discards all buffered words immediately. The first strobe after r rises is accepted on the next rising edge of c.
- Push: on a rising edge with stb=1 and space available, a is written at the write pointer and the write pointer increments modulo DEPTH.
- Pop: on a rising edge with vld=1 and rdy=1, the read pointer increments modulo DEPTH.
- rdy while vld=0 is ignored.
- Push latency: a word strobed at edge N gives vld=1 and y=word after edge N. The output is driven from registered FIFO storage (zero-cycle FWFT read). When the FIFO is empty, y holds the last value read.
- Space available: count<DEPTH, or count=DEPTH with a pop in the same cycle (full FIFO with simultaneous pop and push accepts the push).
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Empty with push: no bypass. The word appears the cycle after the push, never in the same cycle.
- Drop: stb=1, count=DEPTH and no pop. The word is discarded and ovf is set at that edge. Storage and pointers are unchanged.
- ovf clearing: clr=1 clears ovf at the edge. If a drop occurs in the same cycle, set wins and ovf stays 1.
- Count: clog2(DEPTH)+1 bits, range 0..DEPTH. vld=(count!=0), full=(count==DEPTH), both registered-derived.
- Pointers: clog2(DEPTH) bits, wrap naturally.
- Bus contents that are X/Z while stb=1 are stored as-is (simulation only). The block never samples a while stb=0.

Optional Feature:
- Macro: BUS_RX8_PARITY_EN.
- When defined:
  - Adds input ap (1 bit, even parity over {ap,a}) and outputs ype (1) and perr (1).
  - Each FIFO entry stores W+1 bits: data plus a parity-error flag computed at push.
  - ype is the head entry's error flag, aligned with y and qualified by vld.
  - perr is sticky, set when a word with a parity error is pushed, and cleared by clr. Set wins over clear.
  - Reset value of ype and perr is 0.
  - Dropped words do not affect perr.
- When undefined: no ap/ype/perr ports, entry width is W, and behaviour is otherwise identical.

Decomposition:
- Package bus_rx8_pkg holds:
  - default W and DEPTH constants;
  - pointer width PW=clog2(DEPTH) and count width PW+1;
  - a function to compute even parity.
- One sub-module: fifo_ram.
  - Parameterized EW (entry width) x DEPTH register array.
  - Write port: we, wa, wd.
  - Asynchronous read port: ra, rd.
  - No reset on storage.
- Control (pointers, count, flags) lives in bus_rx8.

Test Plan:
- Reset then single word: r low 2 cycles, then stb=1, a=8'hA5 for one edge, rdy=0 → vld=1 and y=8'hA5 next cycle. rdy=1 for one edge → vld=0.
- Fill and overflow: rdy=0, strobe 8'h01..8'h05 on consecutive edges → full=1 after 4th, 5th dropped, ovf=1. Drain with rdy=1 → y=01,02,03,04 then vld=0.
- Full with simultaneous push/pop: FIFO full of 10..13, stb=1 a=8'h14 with rdy=1 → ovf stays 0, count stays 4. Drain order 11,12,13,14.
- Pointer wrap with streaming: stb=1 and rdy=1 every cycle for 20 words 0..19 after one initial push → output sequence matches input exactly, full never 1, vld continuously 1.
- Clear vs drop: ovf=1, clr=1 with no drop → ovf=0. Repeat with clr=1 and a simultaneous drop → ovf remains 1.
- Async reset mid-stream: 3 words buffered, r pulsed low between edges → vld=0, full=0, ovf=0 immediately without a clock. Next strobed 8'h3C appears alone.
- With BUS_RX8_PARITY_EN: push a=8'h03, ap=0 (ok) then a=8'h01, ap=0 (error) → ype=0 for first word, ype=1 for second, perr=1.
